// File: rtl/axi_stream_master.sv
// axi_stream_master: drains a FIFO with one-cycle registered read latency
// into an AXI4-Stream slave at up to one beat per cycle. A 3-entry buffer
// (output register plus 2-entry skid) absorbs reads already in flight, so the
// FIFO read strobe never depends combinationally on tready.
module axi_stream_master #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic                          tvalid,
  input  logic                          tready,
  output logic                          tlast,
  output logic [AXIS_TDATA_WIDTH-1:0]   tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] tstrb,
  input  logic                          fifo_empty,
  output logic                          fifo_rden,
  input  logic [AXIS_TDATA_WIDTH-1:0]   fifo_data,
  input  logic                          fifo_tlast,
  output logic                          pkt_done,
  output logic                          busy
);

  localparam int W = AXIS_TDATA_WIDTH;

  // Beats are carried as {tlast, tdata}.
  logic [W:0] in_beat;
  logic [W:0] out_d;
  logic [W:0] skid0;
  logic [W:0] skid1;
  logic [W:0] skid0_d;
  logic [W:0] skid1_d;
  logic [1:0] occ;
  logic [1:0] occ_d;
  logic       inflight;
  logic       pop;
  logic       arrive;

  assign in_beat = {fifo_tlast, fifo_data};
  assign pop     = tvalid & tready;
  assign arrive  = inflight;
  assign occ_d   = occ + {1'b0, arrive} - {1'b0, pop};
  assign tstrb   = '1;
  assign busy    = (occ != 2'd0) || inflight;

  // Only read when every beat already held or in flight still has a slot;
  // this keeps occ + inflight <= 3 and looks only at registered state.
  assign fifo_rden = resetn && !fifo_empty &&
                     (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

  // Route the arriving beat and shift the skid on a pop, keeping FIFO order.
  always_comb begin
    out_d   = {tlast, tdata};
    skid0_d = skid0;
    skid1_d = skid1;
    if (pop) begin
      if (occ > 2'd1) begin
        out_d   = skid0;
        skid0_d = skid1;
        if (arrive) begin
          if (occ == 2'd3) skid1_d = in_beat;
          else             skid0_d = in_beat;
        end
      end else if (arrive) begin
        out_d = in_beat;
      end
    end else if (arrive) begin
      if (occ == 2'd0)      out_d   = in_beat;
      else if (occ == 2'd1) skid0_d = in_beat;
      else                  skid1_d = in_beat;
    end
  end

  // Buffer state, registered stream outputs and the packet-done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      tdata    <= '0;
      skid0    <= '0;
      skid1    <= '0;
      pkt_done <= 1'b0;
    end else begin
      occ      <= occ_d;
      inflight <= fifo_rden;
      tvalid   <= (occ_d != 2'd0);
      tlast    <= out_d[W];
      tdata    <= out_d[W-1:0];
      skid0    <= skid0_d;
      skid1    <= skid1_d;
      pkt_done <= pop & tlast;
    end
  end

endmodule

// File: tb/tb_axi_stream_master.sv
// tb_axi_stream_master: drives axi_stream_master from a queue-backed FIFO model
// and checks the stream against the order words were written into the FIFO.
module tb_axi_stream_master;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           tvalid;
  logic           tready = 1'b0;
  logic           tlast;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           fifo_empty = 1'b1;
  logic           fifo_rden;
  logic [W-1:0]   fifo_data = '0;
  logic           fifo_tlast = 1'b0;
  logic           pkt_done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Source FIFO contents, expected output order, and cycle of each read.
  logic [W:0] src_q[$];
  logic [W:0] exp_q[$];
  int         rden_cyc[$];

  int         cyc = 0;
  int         rd_count = 0;
  int         xfer_count = 0;
  bit         lat_check = 1'b0;
  bit         prev_stall = 1'b0;
  bit         exp_pkt_done = 1'b0;
  logic [W:0] prev_beat = '0;

  axi_stream_master #(.AXIS_TDATA_WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tvalid     (tvalid),
    .tready     (tready),
    .tlast      (tlast),
    .tdata      (tdata),
    .tstrb      (tstrb),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .fifo_data  (fifo_data),
    .fifo_tlast (fifo_tlast),
    .pkt_done   (pkt_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO with registered read, plus read/transfer counters.
  always @(posedge clk) begin
    if (fifo_rden) begin
      rd_count++;
      rden_cyc.push_back(cyc);
      if (src_q.size() != 0) {fifo_tlast, fifo_data} <= src_q.pop_front();
    end
    if (tvalid && tready) xfer_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d",
               tag, actual, expected, cyc);
    end
  endtask

  task automatic pushWord(input logic [W-1:0] data, input logic last);
    src_q.push_back({last, data});
    exp_q.push_back({last, data});
  endtask

  // One clock cycle: drive inputs at the falling edge, then check the stream.
  task automatic applyStimulus(input bit ready, input bit force_empty, input bit rstn);
    logic [W:0] exp_beat;
    int         lat;
    bit         exp_last;
    @(negedge clk);
    cyc++;
    resetn     = rstn;
    tready     = ready;
    fifo_empty = force_empty || (src_q.size() == 0);
    #1;
    if (resetn) begin
      exp_last = 1'b0;
      checkOutput("rden_rule", fifo_rden,
                  !fifo_empty && ((rd_count - xfer_count) < 3));
      checkOutput("busy", busy, rd_count != xfer_count);
      checkOutput("occ_bound", (rd_count - xfer_count) <= 3, 1);
      checkOutput("pkt_done", pkt_done, exp_pkt_done);
      checkOutput("tstrb", tstrb, {(W/8){1'b1}});
      if (prev_stall) begin
        checkOutput("hold_valid", tvalid, 1);
        checkOutput("hold_beat", {tlast, tdata}, prev_beat);
      end
      if (tvalid && tready) begin
        checkOutput("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          exp_last = exp_beat[W];
          checkOutput("tdata", tdata, exp_beat[W-1:0]);
          checkOutput("tlast", tlast, exp_beat[W]);
        end
        if (rden_cyc.size() != 0) begin
          lat = cyc - rden_cyc.pop_front();
          if (lat_check) checkOutput("latency", lat, 2);
        end
      end
      exp_pkt_done = exp_last;
      prev_stall   = tvalid && !tready;
      prev_beat    = {tlast, tdata};
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      n++;
    end
    checkOutput("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int first_v;
    int first_x;
    int last_x;
    int pulses;
    int n;
    int start;

    // Reset with an empty FIFO: everything quiet.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("rst_tvalid", tvalid, 0);
      checkOutput("rst_tlast", tlast, 0);
      checkOutput("rst_tdata", tdata, 0);
      checkOutput("rst_pkt_done", pkt_done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_rden", fifo_rden, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("idle_rden", fifo_rden, 0);
      checkOutput("idle_tvalid", tvalid, 0);
    end

    // Streaming: 8 words 0..7, tlast on 7, tready always high.
    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) pushWord(W'(i), i == 7);
    lat_check = 1'b1;
    first_v = -1; first_x = -1; last_x = -1; pulses = 0;
    start = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (i == 0) checkOutput("stream_first_rden", fifo_rden, 1);
      if (tvalid && first_v < 0) first_v = cyc - start;
      if (tvalid && tready) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (pkt_done) pulses++;
    end
    checkOutput("stream_first_valid", first_v, 2);
    checkOutput("stream_gapless", last_x - first_x, 7);
    checkOutput("stream_pkt_pulses", pulses, 1);
    checkOutput("stream_left", exp_q.size(), 0);

    // Backpressure: tready low for cycles 3..12, then released.
    $display("[TB] backpressure");
    lat_check = 1'b0;
    for (int i = 0; i < 16; i++) pushWord($urandom, (i % 8) == 7);
    for (int i = 0; i < 21; i++) begin
      applyStimulus(!(i >= 3 && i < 13), 1'b0, 1'b1);
      if (i == 12) begin
        checkOutput("bp_rden_off", fifo_rden, 0);
        checkOutput("bp_full", rd_count - xfer_count, 3);
      end
      if (i >= 13) checkOutput("bp_no_gap", tvalid, 1);
    end
    drain(100);

    // Sparse source: data available only every other cycle.
    $display("[TB] sparse source");
    lat_check = 1'b1;
    for (int i = 0; i < 6; i++) pushWord($urandom, i == 5);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i % 2) == 1, 1'b1);
      if ((i % 2) == 1 && i < 13) checkOutput("sparse_gap", tvalid, 0);
    end
    drain(20);

    // Random ready and random FIFO availability over 1000 beats.
    $display("[TB] random traffic");
    lat_check = 1'b0;
    for (int i = 0; i < 1000; i++) pushWord($urandom, $urandom_range(7, 0) == 0);
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      applyStimulus($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 3, 1'b1);
      n++;
    end
    checkOutput("random_left", exp_q.size(), 0);
    drain(20);

    // Reset in the middle of a packet, then restart from fresh reads.
    $display("[TB] mid-packet reset");
    for (int i = 0; i < 8; i++) pushWord(32'h100 + W'(i), i == 7);
    for (int i = 0; i < 4; i++) applyStimulus(i < 3, 1'b0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_tvalid", tvalid, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_rden", fifo_rden, 0);
    rd_count     = xfer_count;
    exp_q        = src_q;
    rden_cyc.delete();
    prev_stall   = 1'b0;
    exp_pkt_done = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    lat_check = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("release_rden", fifo_rden, 1);
    checkOutput("release_tvalid", tvalid, 0);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
